slot_reel_sequencer: RTL and testbench

//  Sequences one slot-machine game: checks/debits the bet, releases the three reel counters, stops

---
 rtl/slot_pkg.sv | 32 +++
 rtl/slot_btn_edge.sv | 24 ++
 rtl/slot_reel_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_slot_reel_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and payout rules for the slot reel sequencer.
// Optional feature macro used by the top: SLOT_AUTO_STOP_EN.
package slot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSpin0,
        StSpin1,
        StSpin2,
        StEval,
        StPay
    } slot_state_e;

    localparam logic [3:0] PAY_JACKPOT   = 4'd10;
    localparam logic [3:0] PAY_TRIPLE    = 4'd5;
    localparam logic [3:0] PAY_PAIR      = 4'd1;
    localparam logic [3:0] PAY_NONE      = 4'd0;
    localparam logic [3:0] JACKPOT_DIGIT = 4'd7;

    function automatic logic [3:0] slot_payout(input logic [3:0] r0, input logic [3:0] r1,
                                               input logic [3:0] r2);
        if (r0 == JACKPOT_DIGIT && r1 == JACKPOT_DIGIT && r2 == JACKPOT_DIGIT) begin
            return PAY_JACKPOT;
        end else if (r0 == r1 && r1 == r2) begin
            return PAY_TRIPLE;
        end else if (r0 == r1 || r1 == r2) begin
            return PAY_PAIR;
        end
        return PAY_NONE;
    endfunction

endpackage

// File: rtl/slot_btn_edge.sv
// Two-flop synchroniser plus previous-value register; emits a one-cycle pulse per rising edge.
module slot_btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/slot_reel_sequencer.sv
// One slot game: bet debit, left-to-right reel stops, payout offer with valid/ack.
// Define SLOT_AUTO_STOP_EN to stop a reel automatically after AUTO_CYC idle cycles per stage.
module slot_reel_sequencer #(
    parameter int unsigned BET      = 1,
    parameter int unsigned MIN_SPIN = 1000
`ifdef SLOT_AUTO_STOP_EN
    ,
    parameter int unsigned AUTO_CYC = 50000
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [2:0] btn_stop_i,
    input  logic [3:0] reel0_i,
    input  logic [3:0] reel1_i,
    input  logic [3:0] reel2_i,
    input  logic [6:0] credit_i,
    output logic [2:0] stop_o,
    output logic       debit_o,
    output logic       no_credit_o,
    output logic [3:0] payout_o,
    output logic       payout_vld_o,
    input  logic       payout_ack_i,
    output logic       busy_o,
    output logic [3:0] res0_o,
    output logic [3:0] res1_o,
    output logic [3:0] res2_o
);
    import slot_pkg::*;

    localparam int unsigned SpinW = $clog2(MIN_SPIN + 2);

    slot_state_e       state_q, state_d;
    logic [2:0]        stop_q, stop_d;
    logic              debit_q, debit_d;
    logic              no_credit_q, no_credit_d;
    logic [3:0]        payout_q, payout_d;
    logic [2:0][3:0]   res_q, res_d;
    logic [SpinW-1:0]  spin_q, spin_d;

    logic              start_edge;
    logic [2:0]        stop_edge;
    logic [2:0][3:0]   reel;
    logic [1:0]        stage_idx;
    logic              in_spin;
    logic              spin_ok;
    logic              accept;
    logic              auto_fire;
    logic [3:0]        pay_val;

    slot_btn_edge u_start_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (start_i),
        .pulse_o (start_edge)
    );

    for (genvar k = 0; k < 3; k++) begin : gen_stop_edge
        slot_btn_edge u_edge (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .btn_i   (btn_stop_i[k]),
            .pulse_o (stop_edge[k])
        );
    end

    assign reel    = {reel2_i, reel1_i, reel0_i};
    assign in_spin = (state_q == StSpin0) || (state_q == StSpin1) || (state_q == StSpin2);
    assign spin_ok = spin_q >= SpinW'(MIN_SPIN);
    assign pay_val = slot_payout(res_q[0], res_q[1], res_q[2]);

    always_comb begin
        stage_idx = 2'd0;
        case (state_q)
            StSpin1: stage_idx = 2'd1;
            StSpin2: stage_idx = 2'd2;
            default: stage_idx = 2'd0;
        endcase
    end

    // Only the current stage's button counts; other bits in the same cycle are dropped.
    assign accept = in_spin && ((stop_edge[stage_idx] && spin_ok) || auto_fire);

`ifdef SLOT_AUTO_STOP_EN
    localparam int unsigned AutoW = $clog2(AUTO_CYC + 1);

    logic [AutoW-1:0] auto_q, auto_d;
    logic             auto_en;

    // SPIN0 starts its auto window only once the minimum spin time has elapsed.
    assign auto_en   = in_spin && ((state_q != StSpin0) || spin_ok);
    assign auto_fire = auto_en && (auto_q == AutoW'(AUTO_CYC - 1));

    always_comb begin
        auto_d = '0;
        if (in_spin && !accept && auto_en) begin
            auto_d = auto_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        debit_d     = 1'b0;
        no_credit_d = 1'b0;
        payout_d    = payout_q;
        res_d       = res_q;
        spin_d      = spin_q;
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    if (credit_i >= 7'(BET)) begin
                        debit_d = 1'b1;
                        stop_d  = 3'b000;
                        spin_d  = '0;
                        state_d = StSpin0;
                    end else begin
                        no_credit_d = 1'b1;
                    end
                end
            end
            StSpin0, StSpin1, StSpin2: begin
                if (!spin_ok) begin
                    spin_d = spin_q + 1'b1;
                end
                if (accept) begin
                    stop_d[stage_idx] = 1'b1;
                    res_d[stage_idx]  = reel[stage_idx];
                    case (state_q)
                        StSpin0: state_d = StSpin1;
                        StSpin1: state_d = StSpin2;
                        default: state_d = StEval;
                    endcase
                end
            end
            StEval: begin
                payout_d = pay_val;
                state_d  = (pay_val != PAY_NONE) ? StPay : StIdle;
            end
            StPay: begin
                if (payout_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            stop_q      <= 3'b111;
            debit_q     <= 1'b0;
            no_credit_q <= 1'b0;
            payout_q    <= '0;
            res_q       <= '0;
            spin_q      <= '0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            debit_q     <= debit_d;
            no_credit_q <= no_credit_d;
            payout_q    <= payout_d;
            res_q       <= res_d;
            spin_q      <= spin_d;
        end
    end

    assign stop_o       = stop_q;
    assign debit_o      = debit_q;
    assign no_credit_o  = no_credit_q;
    assign payout_o     = payout_q;
    assign payout_vld_o = (state_q == StPay);
    assign busy_o       = (state_q != StIdle);
    assign res0_o       = res_q[0];
    assign res1_o       = res_q[1];
    assign res2_o       = res_q[2];

endmodule

// File: tb/tb_slot_reel_sequencer.sv
// Self-checking bench for slot_reel_sequencer: cycle model plus directed game scenarios.
module tb_slot_reel_sequencer;

    localparam int unsigned BET      = 1;
    localparam int unsigned MIN_SPIN = 4;
    localparam int unsigned AUTO_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [3:0] reel [3];
    logic [6:0] credit = 7'd0;
    logic       ack = 1'b0;

    logic [2:0] stop_o;
    logic       debit_o, no_credit_o, payout_vld_o, busy_o;
    logic [3:0] payout_o, res0_o, res1_o, res2_o;

    int checks = 0;
    int errors = 0;
    int n_debit = 0;
    int n_nocred = 0;

    always #5 clk = ~clk;

    slot_reel_sequencer #(
        .BET      (BET),
        .MIN_SPIN (MIN_SPIN)
`ifdef SLOT_AUTO_STOP_EN
        ,
        .AUTO_CYC (AUTO_CYC)
`endif
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .btn_stop_i   (btn),
        .reel0_i      (reel[0]),
        .reel1_i      (reel[1]),
        .reel2_i      (reel[2]),
        .credit_i     (credit),
        .stop_o       (stop_o),
        .debit_o      (debit_o),
        .no_credit_o  (no_credit_o),
        .payout_o     (payout_o),
        .payout_vld_o (payout_vld_o),
        .payout_ack_i (ack),
        .busy_o       (busy_o),
        .res0_o       (res0_o),
        .res1_o       (res1_o),
        .res2_o       (res2_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_pay(input int a, input int b, input int c);
        if (a == 7 && b == 7 && c == 7) return 4'd10;
        if (a == b && b == c) return 4'd5;
        if (a == b || b == c) return 4'd1;
        return 4'd0;
    endfunction

    // Model: phase 0 idle, 1..3 waiting for reel phase-1, 4 evaluate, 5 offering payout.
    int         m_phase, m_age, m_stage_cnt, mk;
    logic [2:0] m_stop;
    logic [3:0] m_res [3];
    logic [3:0] m_pay;
    logic       m_debit, m_nocred, m_fire;
    logic       sh1, sh2, sh3, s_edge;
    logic [2:0] bh1, bh2, bh3, b_edge;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_age = 0; m_stage_cnt = 0;
            m_stop = 3'b111; m_pay = 0; m_debit = 0; m_nocred = 0;
            for (int i = 0; i < 3; i++) m_res[i] = 0;
            sh1 = 0; sh2 = 0; sh3 = 0; bh1 = 0; bh2 = 0; bh3 = 0;
        end else begin
            // Raw level sampled two edges ago, compared with the one before: seen at this edge.
            s_edge = sh2 & ~sh3;
            b_edge = bh2 & ~bh3;
            m_debit = 0;
            m_nocred = 0;
            case (m_phase)
                0: if (s_edge) begin
                    if (credit >= BET) begin
                        m_debit = 1; m_stop = 3'b000; m_age = 0; m_stage_cnt = 0; m_phase = 1;
                    end else begin
                        m_nocred = 1;
                    end
                end
                1, 2, 3: begin
                    mk = m_phase - 1;
                    m_fire = 0;
`ifdef SLOT_AUTO_STOP_EN
                    if (mk > 0 || m_age >= MIN_SPIN) m_stage_cnt++;
                    if (m_stage_cnt == AUTO_CYC) m_fire = 1;
`endif
                    if ((b_edge[mk] && m_age >= MIN_SPIN) || m_fire) begin
                        m_stop[mk] = 1'b1;
                        m_res[mk] = reel[mk];
                        m_phase++;
                        m_stage_cnt = 0;
                    end
                    m_age++;
                end
                4: begin
                    m_pay = exp_pay(m_res[0], m_res[1], m_res[2]);
                    m_phase = (m_pay != 0) ? 5 : 0;
                end
                default: if (ack) m_phase = 0;
            endcase
            sh3 = sh2; sh2 = sh1; sh1 = start;
            bh3 = bh2; bh2 = bh1; bh1 = btn;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("stop", stop_o, m_stop);
        chk("debit", debit_o, m_debit);
        chk("no_credit", no_credit_o, m_nocred);
        chk("busy", busy_o, m_phase != 0);
        chk("payout_vld", payout_vld_o, m_phase == 5);
        chk("payout", payout_o, m_pay);
        chk("res0", res0_o, m_res[0]);
        chk("res1", res1_o, m_res[1]);
        chk("res2", res2_o, m_res[2]);
    end

    always @(negedge clk) begin
        if (debit_o === 1'b1) n_debit++;
        if (no_credit_o === 1'b1) n_nocred++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic press(input int k);
        @(negedge clk); btn[k] = 1'b1;
        @(negedge clk); btn[k] = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (busy_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", busy_o, 1);
    endtask

    task automatic wait_vld();
        int n = 0;
        while (payout_vld_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("vld_timeout", payout_vld_o, 1);
    endtask

    task automatic play(input int r0, input int r1, input int r2);
        reel[0] = 4'(r0); reel[1] = 4'(r1); reel[2] = 4'(r2);
        press_start();
        wait_busy();
        tick(MIN_SPIN + 1);
        press(0);
        tick(2);
        press(1);
        tick(2);
        press(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int d0, v;
        int t [3];
        reel[0] = 0; reel[1] = 0; reel[2] = 0;
        tick(3);
        chk("rst_stop", stop_o, 3'b111);
        chk("rst_busy", busy_o, 0);
        chk("rst_vld", payout_vld_o, 0);
        rst_n = 1'b1;

        // No credit: refused start.
        d0 = n_debit;
        v = n_nocred;
        credit = 7'd0;
        press_start();
        tick(6);
        chk("nocred_pulses", n_nocred - v, 1);
        chk("nocred_debits", n_debit - d0, 0);
        chk("nocred_stop", stop_o, 3'b111);

        // Jackpot: payout held for three cycles until acknowledged.
        credit = 7'd5;
        d0 = n_debit;
        play(7, 7, 7);
        wait_vld();
        chk("jackpot_payout", payout_o, 10);
        v = 1;
        tick(1); if (payout_vld_o) v++;
        tick(1); if (payout_vld_o) v++;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("jackpot_vld_cycles", v, 3);
        chk("jackpot_vld_drop", payout_vld_o, 0);
        chk("jackpot_debits", n_debit - d0, 1);
        chk("jackpot_stop", stop_o, 3'b111);

        // Pair on the left.
        play(3, 3, 8);
        wait_vld();
        chk("pair_payout", payout_o, 1);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;

        // No win: never offered, back to idle.
        play(1, 2, 3);
        v = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (payout_vld_o) v++;
        end
        chk("nowin_vld_cycles", v, 0);
        chk("nowin_busy", busy_o, 0);

        // Early and out-of-order buttons are ignored.
        reel[0] = 4; reel[1] = 5; reel[2] = 6;
        press_start();
        wait_busy();
        press(0);
        tick(1);
        press(2);
        tick(1);
        press(1);
        tick(3);
        chk("ooo_stop", stop_o, 3'b000);
        press(0);
        tick(3);
        chk("ooo_valid_stop", stop_o, 3'b001);
        chk("ooo_res0", res0_o, 4);
        press(1);
        tick(2);
        press(2);
        tick(6);
        chk("ooo_idle", busy_o, 0);

        // Reset in the middle of SPIN1.
        reel[0] = 9;
        press_start();
        wait_busy();
        tick(MIN_SPIN + 1);
        press(0);
        tick(3);
        chk("mid_stop_before", stop_o, 3'b001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stop", stop_o, 3'b111);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_vld", payout_vld_o, 0);
        chk("mid_rst_res0", res0_o, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("mid_rst_idle", busy_o, 0);

`ifdef SLOT_AUTO_STOP_EN
        // Auto-stop with no buttons: reels stop 24, 44, 64 cycles after entering SPIN0.
        reel[0] = 2; reel[1] = 4; reel[2] = 6;
        t[0] = -1; t[1] = -1; t[2] = -1;
        press_start();
        wait_busy();
        v = 0;
        while (v < 100 && stop_o[2] !== 1'b1) begin
            @(negedge clk);
            v++;
            for (int k = 0; k < 3; k++) if (stop_o[k] === 1'b1 && t[k] < 0) t[k] = v;
        end
        chk("auto_t0", t[0], 24);
        chk("auto_t1", t[1], 44);
        chk("auto_t2", t[2], 64);
        tick(4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
